// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg
//   Shared types and constants for the game-flow controller:
//   - stateT       : controller state enumeration
//   - SCREEN_*     : screen codes presented to the Screens/Audio blocks
//   - clogb()      : index width helper, never narrower than 1 bit
//   - screenOf()   : screen code shown while in a given state
package game_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_TITLE,
        ST_OBJ_RESET,
        ST_PLAY,
        ST_PAUSE,
        ST_LOSE,
        ST_LEVEL_UP,
        ST_WORLD_UP,
        ST_GAME_OVER,
        ST_WIN
    } stateT;

    localparam logic [2:0] SCREEN_TITLE     = 3'd0;
    localparam logic [2:0] SCREEN_PLAY      = 3'd1;
    localparam logic [2:0] SCREEN_LOSE      = 3'd2;
    localparam logic [2:0] SCREEN_WIN       = 3'd3;
    localparam logic [2:0] SCREEN_LEVEL_UP  = 3'd4;
    localparam logic [2:0] SCREEN_WORLD_UP  = 3'd5;
    localparam logic [2:0] SCREEN_PAUSE     = 3'd6;
    localparam logic [2:0] SCREEN_GAME_OVER = 3'd7;

    // Width able to hold the values 0..n-1, at least 1 bit.
    function automatic int unsigned clogb(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // The playfield stays on screen while objects are being reset.
    function automatic logic [2:0] screenOf(input stateT s);
        case (s)
            ST_TITLE:     return SCREEN_TITLE;
            ST_OBJ_RESET: return SCREEN_PLAY;
            ST_PLAY:      return SCREEN_PLAY;
            ST_PAUSE:     return SCREEN_PAUSE;
            ST_LOSE:      return SCREEN_LOSE;
            ST_LEVEL_UP:  return SCREEN_LEVEL_UP;
            ST_WORLD_UP:  return SCREEN_WORLD_UP;
            ST_GAME_OVER: return SCREEN_GAME_OVER;
            ST_WIN:       return SCREEN_WIN;
            default:      return SCREEN_TITLE;
        endcase
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if
//   Bundles the button/event inputs and the game-state outputs of the
//   sequencer.
//   master : input-side driver (button decode / game objects), reads outputs
//   slave  : the sequencer itself
//   Inputs : start_btn, continue_btn, pause_btn, player_dead, level_complete
//   Outputs: level, world, screen, lives, player_disable, obj_reset,
//            audio_select
interface game_sequencer_if #(
    parameter int unsigned LEVEL_W = 2,
    parameter int unsigned WORLD_W = 2,
    parameter int unsigned LIVES_W = 5
);
    logic               start_btn;
    logic               continue_btn;
    logic               pause_btn;
    logic               player_dead;
    logic               level_complete;
    logic [LEVEL_W-1:0] level;
    logic [WORLD_W-1:0] world;
    logic [2:0]         screen;
    logic [LIVES_W-1:0] lives;
    logic               player_disable;
    logic               obj_reset;
    logic [3:0]         audio_select;

    modport master (
        output start_btn, continue_btn, pause_btn, player_dead, level_complete,
        input  level, world, screen, lives, player_disable, obj_reset, audio_select
    );

    modport slave (
        input  start_btn, continue_btn, pause_btn, player_dead, level_complete,
        output level, world, screen, lives, player_disable, obj_reset, audio_select
    );
endinterface

// File: rtl/game_sequencer_btn_edge_detect.sv
// btn_edge_detect
//   Registers a level button and emits a registered one-cycle pulse on each
//   rising edge; a held button yields a single pulse.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   btn   : raw button level
//   pulse : one-cycle rising-edge pulse, one clock after the sampled edge
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    logic btnQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btnQ  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            btnQ  <= btn;
            pulse <= btn & ~btnQ;
        end
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer
//   Game-flow controller: title, play, pause, level/world advance, life loss,
//   game over and win. Every output is registered.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : game_sequencer_if.slave (button/event inputs, game-state outputs)
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned NUM_WORLDS   = 4,
    parameter int unsigned NUM_LEVELS   = 4,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned MAX_LIVES    = 5,
    parameter int unsigned HOLD_CYCLES  = 50000000,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned AUTO_ADVANCE = 0
) (
    input logic             clk,
    input logic             rst,
    game_sequencer_if.slave bus
);
    localparam int unsigned LEVEL_W = clogb(NUM_LEVELS);
    localparam int unsigned WORLD_W = clogb(NUM_WORLDS);
    localparam int unsigned CNT_W   = clogb(MAX_LIVES + 1);
    localparam int unsigned TIMER_W = clogb((HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES);

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [WORLD_W-1:0] LAST_WORLD = WORLD_W'(NUM_WORLDS - 1);
    localparam logic [CNT_W-1:0]   START_C    = CNT_W'(START_LIVES);
    localparam logic [CNT_W-1:0]   MAX_C      = CNT_W'(MAX_LIVES);
    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RST_LAST   = TIMER_W'(RST_CYCLES - 1);
    localparam bit                 AUTO       = (AUTO_ADVANCE != 0);

    stateT                state, stateD;
    logic [LEVEL_W-1:0]   levelQ, levelD;
    logic [WORLD_W-1:0]   worldQ, worldD;
    logic [CNT_W-1:0]     countQ, countD;
    logic [TIMER_W-1:0]   timer, timerLimit;
    logic                 expired;
    logic [MAX_LIVES-1:0] livesQ, livesD;
    logic [2:0]           screenQ;
    logic                 disableQ, objResetQ;
    logic                 startEdge, continueEdge, pauseEdge;

    btn_edge_detect uStart    (.clk(clk), .rst(rst), .btn(bus.start_btn),    .pulse(startEdge));
    btn_edge_detect uContinue (.clk(clk), .rst(rst), .btn(bus.continue_btn), .pulse(continueEdge));
    btn_edge_detect uPause    (.clk(clk), .rst(rst), .btn(bus.pause_btn),    .pulse(pauseEdge));

    // One timer serves both the object-reset pulse and the hold screens; it
    // restarts on every state change and saturates at the active limit.
    assign timerLimit = (state == ST_OBJ_RESET) ? RST_LAST : HOLD_LAST;
    assign expired    = (timer == timerLimit);

    always_comb begin
        stateD = state;
        levelD = levelQ;
        worldD = worldQ;
        countD = countQ;
        livesD = '0;
        case (state)
            ST_TITLE: begin
                if (startEdge) begin
                    stateD = ST_OBJ_RESET;
                    levelD = '0;
                    worldD = '0;
                    countD = START_C;
                end
            end
            ST_OBJ_RESET: begin
                if (expired) stateD = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.player_dead) begin
                    if (countQ > CNT_W'(1)) begin
                        countD = countQ - CNT_W'(1);
                        stateD = ST_LOSE;
                    end else begin
                        countD = '0;
                        stateD = ST_GAME_OVER;
                    end
                end else if (bus.level_complete) begin
                    if (levelQ == LAST_LEVEL && worldQ == LAST_WORLD) begin
                        stateD = ST_WIN;
                    end else if (levelQ == LAST_LEVEL) begin
                        levelD = '0;
                        worldD = worldQ + WORLD_W'(1);
                        countD = (countQ >= MAX_C) ? MAX_C : countQ + CNT_W'(1);
                        stateD = ST_WORLD_UP;
                    end else begin
                        levelD = levelQ + LEVEL_W'(1);
                        stateD = ST_LEVEL_UP;
                    end
                end else if (pauseEdge) begin
                    stateD = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pauseEdge || continueEdge) stateD = ST_PLAY;
            end
            ST_LOSE, ST_LEVEL_UP, ST_WORLD_UP: begin
                if (expired && (continueEdge || AUTO)) stateD = ST_OBJ_RESET;
            end
            ST_GAME_OVER, ST_WIN: begin
                if (startEdge) begin
                    stateD = ST_OBJ_RESET;
                    levelD = '0;
                    worldD = '0;
                    countD = START_C;
                end else if (continueEdge) begin
                    // Back on the title screen the display matches power-up.
                    stateD = ST_TITLE;
                    levelD = '0;
                    worldD = '0;
                    countD = '0;
                end
            end
            default: stateD = ST_TITLE;
        endcase
        for (int unsigned i = 0; i < MAX_LIVES; i++) begin
            livesD[i] = (CNT_W'(i) < countD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_TITLE;
            levelQ    <= '0;
            worldQ    <= '0;
            countQ    <= '0;
            timer     <= '0;
            livesQ    <= '0;
            screenQ   <= SCREEN_TITLE;
            disableQ  <= 1'b1;
            objResetQ <= 1'b0;
        end else begin
            state     <= stateD;
            levelQ    <= levelD;
            worldQ    <= worldD;
            countQ    <= countD;
            if (stateD != state) begin
                timer <= '0;
            end else if (!expired) begin
                timer <= timer + TIMER_W'(1);
            end
            livesQ    <= livesD;
            screenQ   <= screenOf(stateD);
            disableQ  <= (stateD != ST_PLAY);
            objResetQ <= (stateD == ST_OBJ_RESET);
        end
    end

    assign bus.level          = levelQ;
    assign bus.world          = worldQ;
    assign bus.screen         = screenQ;
    assign bus.lives          = livesQ;
    assign bus.player_disable = disableQ;
    assign bus.obj_reset      = objResetQ;
    assign bus.audio_select   = {1'b0, screenQ};

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Two sequencers: dut0 waits for continue (HOLD 20), dut1 auto-advances
//   (HOLD 8). A behavioural model tracks both from the rules of the game and
//   is compared with every output on every falling clock edge; directed
//   literal checks pin the model, then random button traffic follows.
module tb_game_sequencer;
    localparam int NW = 4, NL = 4, SL = 3, ML = 5, RC = 16;
    localparam int HOLD0 = 20, HOLD1 = 8;

    localparam int M_TTL = 0, M_ORST = 1, M_PLY = 2, M_PAU = 3, M_LOS = 4,
                   M_LUP = 5, M_WUP = 6, M_GOV = 7, M_WN = 8;

    localparam int B_START = 1, B_CONT = 2, B_PAUSE = 4, B_DEAD = 8, B_COMP = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   checkEn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    game_sequencer_if #(.LEVEL_W(2), .WORLD_W(2), .LIVES_W(5)) if0 ();
    game_sequencer_if #(.LEVEL_W(2), .WORLD_W(2), .LIVES_W(5)) if1 ();

    game_sequencer #(
        .NUM_WORLDS(NW), .NUM_LEVELS(NL), .START_LIVES(SL), .MAX_LIVES(ML),
        .HOLD_CYCLES(HOLD0), .RST_CYCLES(RC), .AUTO_ADVANCE(0)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    game_sequencer #(
        .NUM_WORLDS(NW), .NUM_LEVELS(NL), .START_LIVES(SL), .MAX_LIVES(ML),
        .HOLD_CYCLES(HOLD1), .RST_CYCLES(RC), .AUTO_ADVANCE(1)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // ---------------- behavioural model ----------------
    int mMode[2], mLvl[2], mWld[2], mCnt[2], mDwell[2];
    bit hSt1[2], hSt2[2], hCo1[2], hCo2[2], hPa1[2], hPa2[2];

    function automatic int holdOf(input int d);
        return (d == 0) ? HOLD0 : HOLD1;
    endfunction

    function automatic int screenFor(input int m);
        case (m)
            M_TTL:  return 0;
            M_ORST: return 1;
            M_PLY:  return 1;
            M_PAU:  return 6;
            M_LOS:  return 2;
            M_LUP:  return 4;
            M_WUP:  return 5;
            M_GOV:  return 7;
            default: return 3;
        endcase
    endfunction

    task automatic modelReset(input int d);
        mMode[d] = M_TTL; mLvl[d] = 0; mWld[d] = 0; mCnt[d] = 0; mDwell[d] = 0;
        hSt1[d] = 0; hSt2[d] = 0; hCo1[d] = 0; hCo2[d] = 0; hPa1[d] = 0; hPa2[d] = 0;
    endtask

    task automatic newGame(input int d, output int nm);
        mLvl[d] = 0; mWld[d] = 0; mCnt[d] = SL; nm = M_ORST;
    endtask

    task automatic modelStep(input int d, input bit st, input bit co, input bit pa,
                             input bit dead, input bit comp);
        bit eSt, eCo, ePa, heldLongEnough;
        int nm;
        // a press is seen one clock after the pin was sampled high
        eSt = hSt1[d] && !hSt2[d];
        eCo = hCo1[d] && !hCo2[d];
        ePa = hPa1[d] && !hPa2[d];
        hSt2[d] = hSt1[d]; hSt1[d] = st;
        hCo2[d] = hCo1[d]; hCo1[d] = co;
        hPa2[d] = hPa1[d]; hPa1[d] = pa;
        heldLongEnough = (mDwell[d] + 1 >= holdOf(d));
        nm = mMode[d];
        case (mMode[d])
            M_TTL: if (eSt) newGame(d, nm);
            M_ORST: if (mDwell[d] + 1 >= RC) nm = M_PLY;
            M_PLY: begin
                if (dead) begin
                    mCnt[d] = mCnt[d] - 1;
                    nm = (mCnt[d] == 0) ? M_GOV : M_LOS;
                end else if (comp) begin
                    if (mLvl[d] == NL - 1 && mWld[d] == NW - 1) nm = M_WN;
                    else if (mLvl[d] == NL - 1) begin
                        mLvl[d] = 0;
                        mWld[d] += 1;
                        if (mCnt[d] < ML) mCnt[d] += 1;
                        nm = M_WUP;
                    end else begin
                        mLvl[d] += 1;
                        nm = M_LUP;
                    end
                end else if (ePa) nm = M_PAU;
            end
            M_PAU: if (ePa || eCo) nm = M_PLY;
            M_LOS, M_LUP, M_WUP: if (heldLongEnough && (eCo || d == 1)) nm = M_ORST;
            default: begin
                if (eSt) newGame(d, nm);
                else if (eCo) begin
                    mLvl[d] = 0; mWld[d] = 0; mCnt[d] = 0; nm = M_TTL;
                end
            end
        endcase
        if (nm != mMode[d]) begin
            mMode[d] = nm;
            mDwell[d] = 0;
        end else begin
            mDwell[d] += 1;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            modelReset(0);
            modelReset(1);
        end else begin
            modelStep(0, if0.start_btn, if0.continue_btn, if0.pause_btn, if0.player_dead, if0.level_complete);
            modelStep(1, if1.start_btn, if1.continue_btn, if1.pause_btn, if1.player_dead, if1.level_complete);
        end
    end

    task automatic compareOne(input int d, input logic [2:0] scr, input logic [1:0] lv,
                              input logic [1:0] wd, input logic [4:0] lives, input logic dis,
                              input logic orst, input logic [3:0] aud);
        logic [2:0] eScr;
        logic [1:0] eLv, eWd;
        logic [4:0] eLives;
        logic       eDis, eObj;
        eScr   = 3'(screenFor(mMode[d]));
        eLv    = 2'(mLvl[d]);
        eWd    = 2'(mWld[d]);
        eLives = 5'((1 << mCnt[d]) - 1);
        eDis   = (mMode[d] != M_PLY);
        eObj   = (mMode[d] == M_ORST);
        vectors++;
        if ({scr, lv, wd, lives, dis, orst, aud} !== {eScr, eLv, eWd, eLives, eDis, eObj, {1'b0, eScr}}) begin
            miscompares++;
            $display("FAIL model dut%0d t=%0t: got scr=%0d lvl=%0d wld=%0d lives=%b dis=%b orst=%b aud=%0d, expected scr=%0d lvl=%0d wld=%0d lives=%b dis=%b orst=%b aud=%0d",
                     d, $time, scr, lv, wd, lives, dis, orst, aud, eScr, eLv, eWd, eLives, eDis, eObj, eScr);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            compareOne(0, if0.screen, if0.level, if0.world, if0.lives, if0.player_disable, if0.obj_reset, if0.audio_select);
            compareOne(1, if1.screen, if1.level, if1.world, if1.lives, if1.player_disable, if1.obj_reset, if1.audio_select);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input int m);
        if (d == 0) begin
            if0.start_btn = m[0]; if0.continue_btn = m[1]; if0.pause_btn = m[2];
            if0.player_dead = m[3]; if0.level_complete = m[4];
        end else begin
            if1.start_btn = m[0]; if1.continue_btn = m[1]; if1.pause_btn = m[2];
            if1.player_dead = m[3]; if1.level_complete = m[4];
        end
    endtask

    // Button press: returns on the first falling edge of the resulting state.
    task automatic press(input int d, input int m);
        drive(d, m); @(negedge clk); drive(d, 0); @(negedge clk);
    endtask

    // Level event held for one sample: returns in the first cycle of the new state.
    task automatic strobe(input int d, input int m);
        drive(d, m); @(negedge clk); drive(d, 0);
    endtask

    task automatic waitPlay(input int d, input string name);
        int n = 0;
        while (((d == 0) ? if0.player_disable : if1.player_disable) !== 1'b0 && n < 60) begin
            @(negedge clk); n++;
        end
        check(name, (d == 0) ? if0.player_disable : if1.player_disable, 0);
    endtask

    task automatic exitHold0(input string name);
        repeat (HOLD0) @(negedge clk);
        press(0, B_CONT);
        waitPlay(0, name);
    endtask

    task automatic randDrive(input int d);
        logic s, c, p;
        s = (d == 0) ? if0.start_btn : if1.start_btn;
        c = (d == 0) ? if0.continue_btn : if1.continue_btn;
        p = (d == 0) ? if0.pause_btn : if1.pause_btn;
        if ($urandom_range(0, 19) == 0) s = ~s;
        if ($urandom_range(0, 5) == 0) c = ~c;
        if ($urandom_range(0, 11) == 0) p = ~p;
        drive(d, {27'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 119) == 0), p, c, s});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        drive(0, 0);
        drive(1, 0);
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        check("reset screen", if0.screen, 0);
        check("reset lives", if0.lives, 0);
        check("reset disable", if0.player_disable, 1);
        #2 rst = 1'b1;
        @(negedge clk);

        // new game: object reset pulse then play
        press(0, B_START);
        check("start obj_reset", if0.obj_reset, 1);
        n = 0;
        while (if0.obj_reset === 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        check("obj_reset length", n, 16);
        check("play screen", if0.screen, 1);
        check("play lives", if0.lives, 5'b00111);
        check("play disable", if0.player_disable, 0);

        // three levels then a world advance
        for (int i = 1; i <= 3; i++) begin
            strobe(0, B_COMP);
            check("level_up screen", if0.screen, 4);
            check("level_up level", if0.level, i);
            exitHold0("level_up exit");
        end
        strobe(0, B_COMP);
        check("world_up screen", if0.screen, 5);
        check("world_up world", if0.world, 1);
        check("world_up level", if0.level, 0);
        check("world_up lives", if0.lives, 5'b01111);
        exitHold0("world_up exit");

        // life loss, early continue ignored
        strobe(0, B_DEAD);
        check("lose screen", if0.screen, 2);
        check("lose lives", if0.lives, 5'b00111);
        press(0, B_CONT);
        check("early continue ignored", if0.screen, 2);
        repeat (HOLD0) @(negedge clk);
        press(0, B_CONT);
        check("late continue obj_reset", if0.obj_reset, 1);
        waitPlay(0, "lose exit");

        // dead beats complete; run out of lives
        strobe(0, B_DEAD | B_COMP);
        check("dead+complete screen", if0.screen, 2);
        check("dead+complete lives", if0.lives, 5'b00011);
        check("dead+complete level", if0.level, 0);
        check("dead+complete world", if0.world, 1);
        exitHold0("lose exit 2");
        strobe(0, B_DEAD);
        check("one life left", if0.lives, 5'b00001);
        exitHold0("lose exit 3");
        strobe(0, B_DEAD);
        check("game_over screen", if0.screen, 7);
        check("game_over lives", if0.lives, 0);

        // start beats continue on game over
        press(0, B_START | B_CONT);
        check("restart obj_reset", if0.obj_reset, 1);
        check("restart lives", if0.lives, 5'b00111);
        check("restart world", if0.world, 0);
        waitPlay(0, "restart play");

        // pause freezes the game
        press(0, B_PAUSE);
        check("pause screen", if0.screen, 6);
        check("pause disable", if0.player_disable, 1);
        drive(0, B_DEAD);
        repeat (4) @(negedge clk);
        drive(0, 0);
        check("dead in pause ignored", if0.screen, 6);
        check("pause lives frozen", if0.lives, 5'b00111);
        press(0, B_PAUSE);
        check("unpause screen", if0.screen, 1);

        // auto-advance unit
        press(1, B_START);
        waitPlay(1, "auto play");
        strobe(1, B_COMP);
        n = 0;
        while (if1.screen === 3'd4 && n < 30) begin
            @(negedge clk); n++;
        end
        check("auto level_up dwell", n, 8);
        check("auto obj_reset", if1.obj_reset, 1);
        waitPlay(1, "auto play 2");
        strobe(1, B_COMP);
        check("auto level_up 2", if1.level, 2);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid-hold reset screen", if1.screen, 0);
        check("mid-hold reset level", if1.level, 0);
        check("mid-hold reset lives", if1.lives, 0);
        check("mid-hold reset disable", if1.player_disable, 1);
        check("mid-hold reset obj_reset", if1.obj_reset, 0);
        check("mid-hold reset audio", if1.audio_select, 0);
        @(negedge clk);
        #2 rst = 1'b1;

        // random traffic on both units
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            randDrive(0);
            randDrive(1);
            if (c == 3000) #2 rst = 1'b0;
            if (c == 3003) #2 rst = 1'b1;
        end
        drive(0, 0);
        drive(1, 0);
        @(negedge clk);
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
